// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 10:1 mux: steps sel over the enabled channels,
// waits SETTLE cycles per channel and captures the fed-back mux output into result.
module mux_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] en_mask,
  input  logic       y_in,
  output logic [3:0] sel,
  output logic       busy,
  output logic       done,
  output logic [9:0] result,
  output logic       result_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_sel, w_sel_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [9:0] r_mask, w_mask_nxt;
  logic [9:0] r_result, w_result_nxt;
  logic       r_rv, w_rv_nxt;
  logic [4:0] w_first, w_next;

  // Lowest set bit of m at or above position from; bit 4 flags that one exists.
  function automatic logic [4:0] find_from(input logic [9:0] m, input logic [4:0] from);
    logic [4:0] f;
    f = 5'd0;
    for (int k = 9; k >= 0; k--) begin
      if (m[k] && (k >= int'(from))) f = {1'b1, 4'(k)};
    end
    return f;
  endfunction

  assign w_first = find_from(en_mask, 5'd0);
  assign w_next  = find_from(r_mask, 5'(r_sel) + 5'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_mask_nxt   = r_mask;
    w_result_nxt = r_result;
    w_rv_nxt     = r_rv;
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_mask_nxt   = en_mask;
          w_result_nxt = 10'd0;
          w_rv_nxt     = 1'b0;
          if (w_first[4]) begin
            w_state_nxt = ST_SETTLE;
            w_sel_nxt   = w_first[3:0];
            w_cnt_nxt   = 4'(SETTLE);
          end else begin
            w_state_nxt = ST_DONE;
            w_rv_nxt    = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_result_nxt[r_sel] = y_in;
        if (w_next[4]) begin
          w_state_nxt = ST_SETTLE;
          w_sel_nxt   = w_next[3:0];
          w_cnt_nxt   = 4'(SETTLE);
        end else begin
          w_state_nxt = ST_DONE;
          w_rv_nxt    = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset also clears the datapath so an interrupted scan leaves no partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel    <= 4'd0;
      r_cnt    <= 4'd0;
      r_mask   <= 10'd0;
      r_result <= 10'd0;
      r_rv     <= 1'b0;
    end else begin
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask   <= w_mask_nxt;
      r_result <= w_result_nxt;
      r_rv     <= w_rv_nxt;
    end
  end

  assign sel          = r_sel;
  assign result       = r_result;
  assign result_valid = r_rv;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: timeline model of the scan plus directed scenarios.
module tb_mux_scan_ctrl;
  localparam int S = 2;

  logic       clk, rst_n, start, y_in;
  logic [9:0] en_mask, ivec;
  logic [3:0] sel;
  logic       busy, done, result_valid;
  logic [9:0] result;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  mux_scan_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en_mask(en_mask), .y_in(y_in),
    .sel(sel), .busy(busy), .done(done), .result(result), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the external mux: ivec holds the levels on I0..I9.
  assign y_in = (sel < 4'd10) ? ivec[sel] : 1'b0;

  // Model: kind 0 idle, 1 scanning, 2 done. While scanning, t counts edges since
  // acceptance; every (S+1)th edge samples one channel of the enabled list.
  int         kind = 0;
  int         t = 0;
  int         chs[$];
  logic [3:0] m_sel = 4'd0;
  logic [9:0] m_res = 10'd0;
  logic       m_rv = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      kind = 0; m_sel = 4'd0; m_res = 10'd0; m_rv = 1'b0;
    end else begin
      case (kind)
        0: if (start) begin
          chs.delete();
          for (int k = 0; k < 10; k++) if (en_mask[k]) chs.push_back(k);
          m_res = 10'd0; m_rv = 1'b0;
          if (chs.size() == 0) begin
            kind = 2; m_rv = 1'b1;
          end else begin
            kind = 1; t = 0; m_sel = 4'(chs[0]);
          end
        end
        1: begin
          t++;
          if (t % (S + 1) == 0) begin
            int i;
            i = t / (S + 1);
            m_res[chs[i-1]] = ivec[chs[i-1]];
            if (i == chs.size()) begin
              kind = 2; m_rv = 1'b1;
            end else begin
              m_sel = 4'(chs[i]);
            end
          end
        end
        default: kind = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      vectors++;
      if (sel !== m_sel || busy !== (kind != 0) || done !== (kind == 2) ||
          result !== m_res || result_valid !== m_rv) begin
        miscompares++;
        $display("FAIL model t=%0t sel=%0d want %0d busy=%b want %b done=%b want %b result=%h want %h rv=%b want %b",
                 $time, sel, m_sel, busy, (kind != 0), done, (kind == 2), result, m_res, result_valid, m_rv);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Pulses start with mask m; returns the edge (relative to acceptance) at which
  // DONE was entered, or -1 if it never came, and the set of channels driven on sel.
  task automatic run_scan(input logic [9:0] m, output int dedge, output logic [9:0] seen);
    en_mask = m; start = 1'b1; dedge = -1; seen = 10'd0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && !done && sel < 4'd10) seen[sel] = 1'b1;
      if (done) begin dedge = k; break; end
    end
  endtask

  initial begin
    int         de, last, ndone;
    logic [9:0] seen;
    rst_n = 1'b0; start = 1'b0; en_mask = 10'd0; ivec = 10'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full scan, odd channels high.
    ivec = 10'h2AA;
    run_scan(10'h3FF, de, seen);
    check("full_done_edge", de, 30);
    check("full_result", result, 10'h2AA);
    check("full_rv", result_valid, 1);
    check("full_seen", seen, 10'h3FF);
    @(negedge clk);
    check("full_done_1cyc", done, 0);
    check("full_rv_hold", result_valid, 1);
    check("full_result_hold", result, 10'h2AA);
    repeat (2) @(negedge clk);

    // Sparse mask: only channels 0 and 9.
    ivec = 10'h3FF;
    run_scan(10'h201, de, seen);
    check("sparse_done_edge", de, 6);
    check("sparse_result", result, 10'h201);
    check("sparse_seen", seen, 10'h201);
    repeat (2) @(negedge clk);

    // Empty mask: immediate done, sel keeps last channel.
    run_scan(10'h000, de, seen);
    check("empty_done_edge", de, 0);
    check("empty_result", result, 0);
    check("empty_rv", result_valid, 1);
    check("empty_sel", sel, 9);
    repeat (2) @(negedge clk);

    // Reset at edge 10 of a full scan discards the partial result.
    ivec = 10'h2AA; en_mask = 10'h3FF; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 9) rst_n = 1'b0;
    end
    @(negedge clk);
    check("midrst_sel", sel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_rv", result_valid, 0);
    rst_n = 1'b1;
    ivec = 10'h004;
    run_scan(10'h00C, de, seen);
    check("postrst_done_edge", de, 6);
    check("postrst_result", result, 10'h004);
    repeat (2) @(negedge clk);

    // Start re-pulsed at edge 5 with a new mask: scan runs unchanged.
    ivec = 10'h0A5; en_mask = 10'h0F0; start = 1'b1; de = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin start = 1'b1; en_mask = 10'h3FF; end
      if (done) begin de = k; break; end
    end
    check("repulse_done_edge", de, 12);
    check("repulse_result", result, 10'h0A0);
    repeat (2) @(negedge clk);

    // Start held high: back-to-back single-channel scans every S+3 cycles.
    ivec = 10'h001; en_mask = 10'h001; start = 1'b1; last = -1; ndone = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        if (last < 0) check("b2b_first_done", k, 3);
        else          check("b2b_interval", k - last, S + 3);
        last = k;
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 20);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
